// File: rtl/m_inst_store_responder.sv
`default_nettype none
// ============================================================================
// Module   : m_inst_store_responder
// Purpose  : Far-end responder of the serial micro-instruction fetch link.
//            Collects a serial address (MSB first), reads the addressed word
//            from a one-cycle-latency control store, and streams the word back
//            MSB first with a valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
module m_inst_store_responder #(
    parameter int M_INST_ADDR_WIDTH = 10,
    parameter int MINST_WIDTH       = 44   // must be at least 3
) (
    input  logic                         sys_clk,
    input  logic                         sys_reset_n,
    input  logic                         m_inst_addr_stream,
    input  logic                         m_inst_addr_valid,
    output logic                         rd_en,
    output logic [M_INST_ADDR_WIDTH-1:0] rd_addr,
    input  logic [MINST_WIDTH-1:0]       rd_data,
    output logic                         minstr_stream,
    output logic                         minstr_valid,
    output logic                         busy,
    output logic                         frame_err
);

    // One counter serves both the address and the data phase.
    localparam int CNT_MAX = (M_INST_ADDR_WIDTH > MINST_WIDTH) ? M_INST_ADDR_WIDTH : MINST_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // The shift register keeps only the bits that survive into the next
    // address; the newest bit is appended combinationally.
    localparam int SR_W    = (M_INST_ADDR_WIDTH > 1) ? M_INST_ADDR_WIDTH - 1 : 1;

    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_ADDR_LAST = CNT_W'(M_INST_ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(MINST_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RECV_ADDR = 3'd1,
        S_READ      = 3'd2,
        S_WAIT      = 3'd3,
        S_SEND      = 3'd4
    } state_t;

    state_t                         state_q;
    logic [SR_W-1:0]                addr_sr_q;
    logic [SR_W-1:0]                addr_sr_d;
    logic [M_INST_ADDR_WIDTH-1:0]   addr_d;
    // The bit on the wire lives in minstr_stream_q; this holds the rest.
    logic [MINST_WIDTH-2:0]         data_sr_q;
    logic [CNT_W-1:0]               cnt_q;
    logic                           rd_en_q;
    logic [M_INST_ADDR_WIDTH-1:0]   rd_addr_q;
    logic                           minstr_stream_q;
    logic                           minstr_valid_q;
    logic                           busy_q;
    logic                           frame_err_q;

    // Address as it would look with the current input bit shifted in.
    generate
        if (M_INST_ADDR_WIDTH > 1) begin : g_addr_multi
            assign addr_d    = {addr_sr_q[M_INST_ADDR_WIDTH-2:0], m_inst_addr_stream};
            assign addr_sr_d = addr_d[M_INST_ADDR_WIDTH-2:0];
        end else begin : g_addr_single
            assign addr_d    = m_inst_addr_stream;
            assign addr_sr_d = addr_sr_q;
        end
    endgenerate

    // Fetch-link FSM with all outputs registered alongside the state.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q         <= S_IDLE;
            addr_sr_q       <= '0;
            data_sr_q       <= '0;
            cnt_q           <= '0;
            rd_en_q         <= 1'b0;
            rd_addr_q       <= '0;
            minstr_stream_q <= 1'b0;
            minstr_valid_q  <= 1'b0;
            busy_q          <= 1'b0;
            frame_err_q     <= 1'b0;
        end else begin
            // Single-cycle pulses default low.
            rd_en_q     <= 1'b0;
            frame_err_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (m_inst_addr_valid) begin
                        addr_sr_q <= addr_sr_d;
                        cnt_q     <= C_CNT_ONE;
                        busy_q    <= 1'b1;
                        if (M_INST_ADDR_WIDTH == 1) begin
                            state_q   <= S_READ;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= addr_d;
                        end else begin
                            state_q <= S_RECV_ADDR;
                        end
                    end
                end

                S_RECV_ADDR: begin
                    if (m_inst_addr_valid) begin
                        addr_sr_q <= addr_sr_d;
                        cnt_q     <= cnt_q + C_CNT_ONE;
                        if (cnt_q == C_ADDR_LAST) begin
                            state_q   <= S_READ;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= addr_d;
                        end
                    end else begin
                        // Gap inside the frame: drop the partial address.
                        frame_err_q <= 1'b1;
                        cnt_q       <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                S_READ: begin
                    state_q <= S_WAIT;
                end

                S_WAIT: begin
                    // Store data is valid now; first bit goes straight out.
                    data_sr_q       <= rd_data[MINST_WIDTH-2:0];
                    minstr_stream_q <= rd_data[MINST_WIDTH-1];
                    minstr_valid_q  <= 1'b1;
                    cnt_q           <= '0;
                    state_q         <= S_SEND;
                end

                S_SEND: begin
                    if (cnt_q == C_DATA_LAST) begin
                        minstr_stream_q <= 1'b0;
                        minstr_valid_q  <= 1'b0;
                        busy_q          <= 1'b0;
                        cnt_q           <= '0;
                        state_q         <= S_IDLE;
                    end else begin
                        minstr_stream_q <= data_sr_q[MINST_WIDTH-2];
                        data_sr_q       <= {data_sr_q[MINST_WIDTH-3:0], 1'b0};
                        cnt_q           <= cnt_q + C_CNT_ONE;
                    end
                end

                default: begin
                    state_q         <= S_IDLE;
                    cnt_q           <= '0;
                    minstr_stream_q <= 1'b0;
                    minstr_valid_q  <= 1'b0;
                    busy_q          <= 1'b0;
                end
            endcase
        end
    end

    assign rd_en         = rd_en_q;
    assign rd_addr       = rd_addr_q;
    assign minstr_stream = minstr_stream_q;
    assign minstr_valid  = minstr_valid_q;
    assign busy          = busy_q;
    assign frame_err     = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_m_inst_store_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_inst_store_responder
// Purpose  : Self-checking bench for m_inst_store_responder with a frame-level
//            reference model and a control-store model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_inst_store_responder;

    localparam int AW = 10;
    localparam int MW = 44;

    logic          clk;
    logic          rst_n;
    logic          a_bit;
    logic          a_vld;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [MW-1:0] rd_data;
    logic          m_bit;
    logic          m_vld;
    logic          busy;
    logic          ferr;

    int n_tests = 0;
    int n_fail  = 0;

    m_inst_store_responder #(
        .M_INST_ADDR_WIDTH (AW),
        .MINST_WIDTH       (MW)
    ) u_dut (
        .sys_clk            (clk),
        .sys_reset_n        (rst_n),
        .m_inst_addr_stream (a_bit),
        .m_inst_addr_valid  (a_vld),
        .rd_en              (rd_en),
        .rd_addr            (rd_addr),
        .rd_data            (rd_data),
        .minstr_stream      (m_bit),
        .minstr_valid       (m_vld),
        .busy               (busy),
        .frame_err          (ferr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [MW-1:0] mem [0:(1<<AW)-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    int            cyc      = 0;
    int            m_n      = -1000;  // edge at which the last address bit was taken
    int            m_ferr   = -1000;  // cycle in which frame_err must be high
    int            m_accept = 0;      // first edge at which a new frame bit is accepted
    int            m_nbits  = 0;      // address bits collected in the current frame
    logic [AW-1:0] m_acc    = '0;
    logic [AW-1:0] m_addr   = '0;
    logic [MW-1:0] m_word   = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_n = -1000; m_ferr = -1000; m_accept = 0; m_nbits = 0;
                m_acc = '0; m_addr = '0; m_word = '0;
            end else begin
                cyc++;
                if (cyc >= m_accept) begin
                    if (m_nbits == 0) begin
                        if (a_vld) begin
                            m_acc   = {m_acc[AW-2:0], a_bit};
                            m_nbits = 1;
                        end
                    end else if (a_vld) begin
                        m_acc   = {m_acc[AW-2:0], a_bit};
                        m_nbits = m_nbits + 1;
                    end else begin
                        m_ferr  = cyc;
                        m_nbits = 0;
                    end
                    if (m_nbits == AW) begin
                        m_n      = cyc;
                        m_addr   = m_acc;
                        m_word   = mem[m_acc];
                        m_nbits  = 0;
                        // read + wait + MW send cycles, then one idle cycle
                        m_accept = cyc + MW + 3;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        int   k;
        logic ev;
        forever begin
            @(negedge clk);
            k  = cyc - m_n - 2;
            ev = (k >= 0) && (k < MW);
            chk("cyc rd_en",         64'(rd_en), 64'(cyc == m_n));
            chk("cyc rd_addr",       64'(rd_addr), 64'(m_addr));
            chk("cyc minstr_valid",  64'(m_vld), 64'(ev));
            chk("cyc minstr_stream", 64'(m_bit), ev ? 64'(m_word[MW-1-k]) : 64'd0);
            chk("cyc busy",          64'(busy),
                64'((m_nbits > 0) || ((cyc >= m_n) && (cyc <= m_n + MW + 1))));
            chk("cyc frame_err",     64'(ferr), 64'(cyc == m_ferr));
        end
    end

    // ---------------- control-store model: data valid the cycle after rd_en ----------------
    initial begin
        logic          st_pend;
        logic [AW-1:0] st_addr;
        st_pend = 1'b0;
        st_addr = '0;
        rd_data = '0;
        forever begin
            @(negedge clk);
            if (st_pend) rd_data = mem[st_addr];
            else         rd_data = MW'({$urandom, $urandom});
            st_pend = rd_en;
            st_addr = rd_addr;
        end
    end

    // ---------------- output capture for literal checks ----------------
    logic [MW-1:0] words_q [$];
    int            lens_q  [$];
    logic [AW-1:0] addrs_q [$];
    int            rden_cnt = 0;
    int            ferr_cnt = 0;

    initial begin
        logic [MW-1:0] cap;
        int            capn;
        cap  = '0;
        capn = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                capn = 0;
            end else begin
                if (m_vld) begin
                    cap  = {cap[MW-2:0], m_bit};
                    capn = capn + 1;
                end else if (capn > 0) begin
                    words_q.push_back(cap);
                    lens_q.push_back(capn);
                    capn = 0;
                end
                if (rd_en) begin
                    addrs_q.push_back(rd_addr);
                    rden_cnt++;
                end
                if (ferr) ferr_cnt++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_cycle(input logic v, input logic b);
        @(negedge clk);
        a_vld = v;
        a_bit = b;
    endtask

    task automatic send_addr(input logic [AW-1:0] a);
        for (int i = AW - 1; i >= 0; i--) drive_cycle(1'b1, a[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(1'b0, 1'b0);
    endtask

    task automatic expect_frame(input string nm, input logic [AW-1:0] a, input logic [MW-1:0] w);
        logic [AW-1:0] ga;
        logic [MW-1:0] gw;
        int            gl;
        ga = ~a;
        gw = ~w;
        gl = 0;
        if (addrs_q.size() > 0) ga = addrs_q.pop_front();
        if (words_q.size() > 0) begin
            gw = words_q.pop_front();
            gl = lens_q.pop_front();
        end
        chk({nm, " rd_addr"}, 64'(ga), 64'(a));
        chk({nm, " word"},    64'(gw), 64'(w));
        chk({nm, " length"},  64'(gl), 64'(MW));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [MW-1:0] w_rst;
        for (int i = 0; i < (1 << AW); i++) begin
            logic [AW-1:0] a;
            a = i[AW-1:0];
            mem[i] = {a, ~a, 12'hC3C, a, 2'b01};
        end
        mem[10'h2A5] = 44'hA5A_5A5A_5A5A;
        mem[10'h000] = 44'h000_0000_0001;
        mem[10'h3FF] = 44'hFFF_FFFF_FFFF;
        mem[10'h155] = 44'h123_4567_89AB;
        mem[10'h31C] = 44'h5A5_A5A5_A5A5;
        mem[10'h0F3] = 44'hDEA_DBEE_F012;

        rst_n = 1'b1;
        a_vld = 1'b0;
        a_bit = 1'b0;
        #1 rst_n = 1'b0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset rd_en",        64'(rd_en), 64'd0);
        chk("reset rd_addr",      64'(rd_addr), 64'd0);
        chk("reset minstr_valid", 64'(m_vld), 64'd0);
        chk("reset busy",         64'(busy), 64'd0);
        chk("reset frame_err",    64'(ferr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // nominal fetch
        rden_cnt = 0;
        send_addr(10'h2A5);
        idle(50);
        expect_frame("nominal", 10'h2A5, 44'hA5A_5A5A_5A5A);
        chk("nominal rd_en count", 64'(rden_cnt), 64'd1);
        chk("model addr pin", 64'(m_addr), 64'h2A5);
        chk("model word pin", 64'(m_word), 64'hA5A_5A5A_5A5A);

        // boundary addresses, second frame on the first idle cycle
        rden_cnt = 0;
        send_addr(10'h000);
        idle(46);
        send_addr(10'h3FF);
        idle(50);
        expect_frame("b2b first",  10'h000, 44'h000_0000_0001);
        expect_frame("b2b second", 10'h3FF, 44'hFFF_FFFF_FFFF);
        chk("b2b rd_en count", 64'(rden_cnt), 64'd2);

        // aborted frame after 6 bits
        rden_cnt = 0;
        ferr_cnt = 0;
        for (int i = AW - 1; i >= AW - 6; i--) drive_cycle(1'b1, i[0]);
        drive_cycle(1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("abort frame_err", 64'(ferr), 64'd1);
        chk("abort busy",      64'(busy), 64'd0);
        chk("abort no rd_en",  64'(rden_cnt), 64'd0);
        idle(3);
        send_addr(10'h155);
        idle(50);
        chk("abort frame_err cycles", 64'(ferr_cnt), 64'd1);
        chk("abort rd_en count",      64'(rden_cnt), 64'd1);
        expect_frame("after abort", 10'h155, 44'h123_4567_89AB);

        // spurious valid/bits throughout READ/WAIT/SEND
        rden_cnt = 0;
        ferr_cnt = 0;
        send_addr(10'h31C);
        repeat (46) drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle(50);
        chk("spurious frame_err", 64'(ferr_cnt), 64'd0);
        chk("spurious rd_en count", 64'(rden_cnt), 64'd1);
        expect_frame("spurious", 10'h31C, 44'h5A5_A5A5_A5A5);

        // asynchronous reset while bit 20 is on the wire
        w_rst = 44'hDEA_DBEE_F012;
        send_addr(10'h0F3);
        idle(22);
        @(posedge clk);
        #2;
        chk("pre-reset minstr_valid",  64'(m_vld), 64'd1);
        chk("pre-reset minstr_stream", 64'(m_bit), 64'(w_rst[MW-1-20]));
        rst_n = 1'b0;
        #1;
        chk("async rst minstr_valid",  64'(m_vld), 64'd0);
        chk("async rst busy",          64'(busy), 64'd0);
        chk("async rst rd_en",         64'(rd_en), 64'd0);
        chk("async rst minstr_stream", 64'(m_bit), 64'd0);
        chk("async rst rd_addr",       64'(rd_addr), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset dropped partial word", 64'(words_q.size()), 64'd0);
        addrs_q.delete();
        rden_cnt = 0;
        send_addr(10'h0F3);
        idle(50);
        expect_frame("after reset", 10'h0F3, w_rst);
        chk("after reset rd_en count", 64'(rden_cnt), 64'd1);

        idle(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/m_inst_store_responder.md
Name: m_inst_store_responder

Overview:
- Far-end responder for the serial micro-instruction fetch link.
- Deserialises the micro-instruction address that the CPU streams out MSB first during FETCH_MINST.
- Reads the addressed word from a synchronous micro-instruction store through a one-cycle-latency read port, then streams the MINST_WIDTH-bit word back to the CPU serially, MSB first, with a valid strobe.
- Sits between the CPU's address serialiser and micro-instruction register, and the control-store memory (on-board ROM model or FPGA BRAM).

Parameters:
- M_INST_ADDR_WIDTH, 10: serial address length in bits; also the width of rd_addr.
- MINST_WIDTH, 44: micro-instruction width; also the number of bits streamed back.

Ports:
- sys_clk, input, 1: system clock; all logic on the rising edge.
- sys_reset_n, input, 1: asynchronous active-low reset.
- m_inst_addr_stream, input, 1: serial address bit, MSB first.
- m_inst_addr_valid, input, 1: high on every cycle m_inst_addr_stream carries an address bit.
- rd_en, output, 1: store read strobe, one-cycle pulse.
- rd_addr, output, M_INST_ADDR_WIDTH: store read address.
- rd_data, input, MINST_WIDTH: store read data, valid the cycle after rd_en.
- minstr_stream, output, 1: serial micro-instruction bit, MSB first.
- minstr_valid, output, 1: high on every cycle minstr_stream carries a data bit.
- busy, output, 1: high in any state other than IDLE.
- frame_err, output, 1: one-cycle pulse when an address frame is aborted.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; address shift register and data shift register cleared.
  - Bit counter = 0.
  - rd_en = 0, rd_addr = 0, minstr_stream = 0, minstr_valid = 0, busy = 0, frame_err = 0.
  - Reset asserted in any state aborts immediately. No partial output is resumed after release.
- States: IDLE, RECV_ADDR, READ, WAIT, SEND.
- IDLE:
  - On an edge with m_inst_addr_valid = 1, shift in the bit, set bit counter = 1, go to RECV_ADDR.
  - If M_INST_ADDR_WIDTH == 1, go directly to READ.
- RECV_ADDR:
  - Each edge with valid = 1: addr_sr <= {addr_sr[W-2:0], bit}; counter += 1.
  - When the M_INST_ADDR_WIDTH-th bit is sampled, go to READ.
  - If valid = 0 before the frame completes: pulse frame_err for one cycle, clear the counter, go to IDLE. The partial address is discarded.
- READ (exactly 1 cycle):
  - rd_en = 1 and rd_addr = assembled address (rd_addr is registered, stable from READ until the next READ).
  - Next state WAIT.
- WAIT (exactly 1 cycle):
  - rd_data is sampled at the end of this cycle into data_sr.
  - Next state SEND, counter = 0.
- SEND:
  - minstr_valid = 1 and minstr_stream = data_sr[MINST_WIDTH-1] on each cycle.
  - Each edge shifts data_sr left by one and increments the counter.
  - After MINST_WIDTH cycles, go to IDLE. minstr_valid and minstr_stream are 0 in the following cycle.
- Latency: if the last address bit is sampled at edge N, then:
  - rd_en is high in cycle N..N+1.
  - The first data bit is presented in cycle N+2..N+3.
  - The last data bit is presented in cycle N+1+MINST_WIDTH.
- m_inst_addr_valid during READ, WAIT or SEND is ignored: the bits are discarded, no error is raised and busy stays 1. A new frame is only accepted in IDLE.
- Back-to-back operation: a valid bit on the first IDLE cycle after SEND starts a new frame, with no dead cycle required.
- minstr_stream is 0 whenever minstr_valid is 0.
- rd_data is not sampled outside WAIT.

Test Plan:
- Reset mid-SEND: assert sys_reset_n = 0 asynchronously at bit 20 -> minstr_valid, busy, rd_en and minstr_stream drop to 0 without waiting for a clock edge; release reset, then a fresh frame completes normally.
- Nominal fetch: stream 10'h2A5 MSB first over 10 valid cycles, store returns 44'hA5A_5A5A_5A5A -> rd_en pulses once with rd_addr = 0x2A5; 44 valid bits follow 2 cycles after the last address bit, MSB first, reassembling to 44'hA5A_5A5A_5A5A; busy falls after the last bit.
- Boundary addresses: 10'h000 then 10'h3FF back-to-back, with the second frame starting on the first IDLE cycle -> rd_addr = 0x000 then 0x3FF; data 44'h000_0000_0001 and 44'hFFF_FFFF_FFFF are returned intact with no dropped or duplicated bits.
- Aborted frame: drop valid after 6 bits -> frame_err is high for exactly 1 cycle, no rd_en, busy = 0; a following full 10'h155 frame reads address 0x155.
- Spurious input: toggle m_inst_addr_valid with random bits throughout SEND -> output bits unchanged, no frame_err, no extra rd_en; busy stays 1 until the 44th bit.
